// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder for the readM/writeM/inputReady CPU bus
module mem_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDR_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 busy,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DRIVE,
    S_RESPOND,
    S_HOLD
  } state_t;

  localparam logic [3:0] RL_M1 = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WL_M1 = 4'(WRITE_LATENCY - 1);
  localparam int         DEPTH = 1 << ADDR_BITS;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 is_read_q, is_read_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 error_q, error_d;
  logic                 commit;
  logic                 hold_exit;
  logic                 eval_idle;
  logic                 data_oe;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // HOLD leaves when the accepting request drops or the CPU moves to another address.
  assign hold_exit = (is_read_q ? !readM : !writeM) || (address != addr_q);
  assign eval_idle = (state_q == S_IDLE) || ((state_q == S_HOLD) && hold_exit);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    error_d   = error_q;
    commit    = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (is_read_q) begin
            state_d = S_DRIVE;
          end else begin
            commit  = 1'b1;
            state_d = S_RESPOND;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DRIVE:   state_d = S_RESPOND;
      S_RESPOND: state_d = S_HOLD;
      S_HOLD:    if (hold_exit) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // IDLE acceptance, also taken on the HOLD exit edge so back-to-back fetches lose no cycle.
    if (eval_idle) begin
      if (readM && writeM) begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end else if (readM || writeM) begin
        state_d   = S_WAIT;
        is_read_d = readM;
        addr_d    = address;
        wdata_d   = data;
        cnt_d     = readM ? RL_M1 : WL_M1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      error_q   <= error_d;
    end
  end

  // Storage survives reset; a write caught mid-WAIT never reaches commit.
  always_ff @(posedge clk) begin
    if (commit) mem[addr_q[ADDR_BITS-1:0]] <= wdata_q;
  end

  assign data_oe = is_read_q && !writeM &&
                   ((state_q == S_DRIVE) || (state_q == S_RESPOND) || (state_q == S_HOLD));
  assign data       = data_oe ? mem[addr_q[ADDR_BITS-1:0]] : 'z;
  assign inputReady = (state_q == S_RESPOND);
  assign busy       = (state_q != S_IDLE);
  assign error      = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        inputReady;
  logic        busy;
  logic        error;
  logic        cpu_oe;
  logic [15:0] cpu_wdata;

  int tests_run;
  int tests_failed;

  assign data = cpu_oe ? cpu_wdata : 'z;

  mem_responder #(
    .WORD_SIZE    (16),
    .ADDR_BITS    (8),
    .READ_LATENCY (2),
    .WRITE_LATENCY(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .readM     (readM),
    .writeM    (writeM),
    .address   (address),
    .data      (data),
    .inputReady(inputReady),
    .busy      (busy),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    address   = a;
    cpu_wdata = d;
    cpu_oe    = 1'b1;
    writeM    = 1'b1;
    tick();
    check("wr_busy_e0", busy, 1);
    check("wr_ir_e0", inputReady, 0);
    tick();
    check("wr_ir_e1", inputReady, 0);
    tick();
    check("wr_ir_e2", inputReady, 1);
    check("wr_no_drive", dut.data_oe, 0);
    tick();
    check("wr_ir_e3", inputReady, 0);
    writeM = 1'b0;
    cpu_oe = 1'b0;
    tick();
    check("wr_busy_end", busy, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
    address = a;
    readM   = 1'b1;
    tick();
    check("rd_busy_e0", busy, 1);
    tick();
    check("rd_oe_e1", dut.data_oe, 0);
    tick();
    check("rd_oe_e2", dut.data_oe, 1);
    check("rd_data_e2", data, exp);
    check("rd_ir_e2", inputReady, 0);
    tick();
    check("rd_ir_e3", inputReady, 1);
    check("rd_data_e3", data, exp);
    tick();
    check("rd_ir_e4", inputReady, 0);
    check("rd_hold_data", data, exp);
    readM = 1'b0;
    tick();
    check("rd_busy_end", busy, 0);
    check("rd_oe_end", dut.data_oe, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    readM        = 1'b0;
    writeM       = 1'b0;
    address      = '0;
    cpu_oe       = 1'b0;
    cpu_wdata    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", inputReady, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_oe", dut.data_oe, 0);
    reset_n = 1'b1;
    tick();

    do_write(16'h0005, 16'h1234);
    do_read(16'h0005, 16'h1234);
    do_write(16'h0010, 16'hBEEF);
    do_read(16'h0010, 16'hBEEF);

    // Back-to-back reads with readM held high.
    do_write(16'h0003, 16'h3333);
    do_write(16'h0004, 16'h4444);
    address = 16'h0003;
    readM   = 1'b1;
    repeat (3) tick();
    check("b2b_d0_e2", data, 16'h3333);
    tick();
    check("b2b_ir0", inputReady, 1);
    tick();
    tick();
    check("b2b_hold_stays", busy, 1);
    check("b2b_no_repulse", inputReady, 0);
    check("b2b_hold_data", data, 16'h3333);
    address = 16'h0004;
    tick();
    check("b2b_reaccept_busy", busy, 1);
    check("b2b_reaccept_wait", dut.data_oe, 0);
    tick();
    tick();
    check("b2b_d1", data, 16'h4444);
    check("b2b_ir1_low", inputReady, 0);
    tick();
    check("b2b_ir1", inputReady, 1);
    tick();
    check("b2b_ir1_fall", inputReady, 0);
    readM = 1'b0;
    tick();
    check("b2b_busy_end", busy, 0);

    // Simultaneous read and write requests.
    address   = 16'h0005;
    cpu_wdata = 16'hDEAD;
    cpu_oe    = 1'b1;
    readM     = 1'b1;
    writeM    = 1'b1;
    tick();
    check("err_set", error, 1);
    check("err_busy", busy, 0);
    readM  = 1'b0;
    writeM = 1'b0;
    cpu_oe = 1'b0;
    tick();
    check("err_sticky", error, 1);
    do_read(16'h0005, 16'h1234);
    check("err_sticky2", error, 1);
    reset_n = 1'b0;
    #2;
    check("err_cleared", error, 0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a write's WAIT discards it.
    do_write(16'h0007, 16'h7777);
    address   = 16'h0007;
    cpu_wdata = 16'h0BAD;
    cpu_oe    = 1'b1;
    writeM    = 1'b1;
    tick();
    check("rstw_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("rstw_busy_async", busy, 0);
    check("rstw_ir", inputReady, 0);
    check("rstw_oe", dut.data_oe, 0);
    tick();
    tick();
    writeM = 1'b0;
    cpu_oe = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    do_read(16'h0007, 16'h7777);

    // Upper address bits are ignored.
    do_write(16'h0105, 16'hAAAA);
    do_read(16'h0005, 16'hAAAA);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
